// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and transmit-arbiter FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int BIT_RATE    = 115_200;
    localparam int UART_DATA_W = 8;

    // Arbiter FSM encodings
    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request found when searching upward from last+1 with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest request after 'last' wins
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last) + off) % N_REQ);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one uart_tx serializer between
//               N_REQ byte sources, with burst limit and idle-grant timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = UART_DATA_W,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                    clk_i,
    input  logic                    nreset_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]       tx_data_o,
    output logic                    tx_ready_o,
    input  logic                    tx_valid_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);
    localparam logic [IDLE_W-1:0]  IDLE_SAT   = IDLE_W'(IDLE_TIMEOUT);
    // The cycle that brings idle_cnt up to IDLE_TIMEOUT is the one that releases the grant
    localparam logic [IDLE_W-1:0]  IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT - 1);

    logic [ST_W-1:0]    state;
    logic [ST_W-1:0]    state_nxt;
    logic [IDX_W-1:0]   g;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [DATA_W-1:0]  hold;
    logic               hold_last;
    logic [BURST_W-1:0] burst_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [N_REQ-1:0]   g_onehot;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               timeout_hit;
    logic               rotate;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (req_valid_i),
        .last (last_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    generate
        for (genvar k = 0; k < N_REQ; k++) begin : g_onehot_dec
            assign g_onehot[k] = (g == IDX_W'(k));
        end
    endgenerate

    assign sel_valid   = req_valid_i[g];
    assign sel_last    = req_last_i[g];
    assign timeout_hit = !sel_valid && (idle_cnt >= IDLE_LIMIT);
    assign rotate      = hold_last || (burst_cnt == BURST_MAX);

    // Select the granted requester's data lane
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (g == IDX_W'(k)) begin
                sel_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_any) state_nxt = ST_XFER;
            ST_XFER: begin
                if (sel_valid)        state_nxt = ST_SEND;
                else if (timeout_hit) state_nxt = ST_IDLE;
            end
            ST_SEND: begin
                if (tx_valid_i) state_nxt = rotate ? ST_IDLE : ST_XFER;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant, hold register, burst/idle counters and round-robin pointer
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            g          <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            hold       <= '0;
            hold_last  <= 1'b0;
            burst_cnt  <= '0;
            idle_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        g         <= pick_idx;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                    end
                end
                ST_XFER: begin
                    if (sel_valid) begin
                        hold      <= sel_data;
                        hold_last <= sel_last;
                        if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + BURST_W'(1);
                        idle_cnt  <= '0;
                    end else if (timeout_hit) begin
                        last_grant <= g;
                        idle_cnt   <= '0;
                    end else if (idle_cnt != IDLE_SAT) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                ST_SEND: begin
                    if (tx_valid_i) begin
                        if (rotate) last_grant <= g;
                        else        idle_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; tx_ready_o falls as soon as reset forces IDLE
    always_comb begin
        req_ready_o = (state == ST_XFER) ? g_onehot : '0;
        grant_o     = (state != ST_IDLE) ? g_onehot : '0;
        tx_ready_o  = (state == ST_SEND);
        tx_data_o   = (state == ST_SEND) ? hold : '0;
        busy_o      = (state != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        clk;
    logic        nreset_i;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_last_i;
    logic [3:0]  req_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_o;
    logic        tx_valid_i;
    logic [3:0]  grant_o;
    logic        busy_o;

    int total;
    int bad;

    // Requester byte sources
    logic [7:0] sd [4][16];
    bit         sl [4][16];
    int         slen [4];
    int         sptr [4];
    logic [3:0] force_valid;

    // Consumed-byte log
    logic [7:0] lg_data  [64];
    logic [3:0] lg_grant [64];
    int         lg_n;
    int         win_n;
    bit         prev_ready;
    bit         auto_tx;
    int         wcnt;

    uart_tx_arbiter #(
        .N_REQ        (4),
        .DATA_W       (8),
        .MAX_BURST    (4),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk_i       (clk),
        .nreset_i    (nreset_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_o  (tx_ready_o),
        .tx_valid_i  (tx_valid_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_reqs();
        for (int k = 0; k < 4; k++) begin
            if (sptr[k] < slen[k]) begin
                req_valid_i[k]         = 1'b1;
                req_data_i[k*8 +: 8]   = sd[k][sptr[k]];
                req_last_i[k]          = sl[k][sptr[k]];
            end else begin
                req_valid_i[k]         = 1'b0;
                req_data_i[k*8 +: 8]   = 8'h00;
                req_last_i[k]          = 1'b0;
            end
            if (force_valid[k]) req_valid_i[k] = 1'b1;
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < 4; k++) begin
            slen[k] = 0;
            sptr[k] = 0;
        end
        force_valid = 4'b0;
        lg_n        = 0;
        win_n       = 0;
        prev_ready  = 1'b0;
        wcnt        = 0;
        auto_tx     = 1'b0;
        tx_valid_i  = 1'b0;
        drive_reqs();
    endtask

    // One clock: log consumption, advance sources, model uart_tx, redrive
    task automatic step();
        logic [3:0] hs;
        hs = req_ready_o & req_valid_i;
        if (tx_valid_i && tx_ready_o && lg_n < 64) begin
            lg_data[lg_n]  = tx_data_o;
            lg_grant[lg_n] = grant_o;
            lg_n++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) if (hs[k]) sptr[k]++;
        tx_valid_i = 1'b0;
        if (tx_ready_o && !prev_ready) win_n++;
        prev_ready = tx_ready_o;
        if (auto_tx && tx_ready_o) begin
            wcnt++;
            if (wcnt >= 2) begin
                tx_valid_i = 1'b1;
                wcnt       = 0;
            end
        end else begin
            wcnt = 0;
        end
        drive_reqs();
    endtask

    task automatic do_reset();
        nreset_i = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        nreset_i = 1'b1;
    endtask

    task automatic run_bytes(input int n);
        for (int c = 0; c < 300 && lg_n < n; c++) step();
        total++;
        if (lg_n != n) begin
            bad++;
            $display("FAIL byte_count: got %0d want %0d", lg_n, n);
        end
    endtask

    task automatic test_reset();
        nreset_i = 1'b0;
        clear_all();
        #1;
        total++;
        if ({grant_o, req_ready_o, tx_ready_o, busy_o, tx_data_o} !== 18'h0) begin
            bad++;
            $display("FAIL reset_outputs: got grant=%b ready=%b txr=%b busy=%b data=%h want all 0",
                     grant_o, req_ready_o, tx_ready_o, busy_o, tx_data_o);
        end
        do_reset();
        slen[0] = 1; sd[0][0] = 8'hA5; sl[0][0] = 1'b1;
        drive_reqs();
        step();
        step();
        total++;
        if (tx_ready_o !== 1'b1 || tx_data_o !== 8'hA5) begin
            bad++;
            $display("FAIL reset_pre_send: got txr=%b data=%h want 1 a5", tx_ready_o, tx_data_o);
        end
        #2;
        nreset_i = 1'b0;
        #1;
        total++;
        if (tx_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_async_txr: got %b want 0", tx_ready_o);
        end
        total++;
        if (grant_o !== 4'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_async_grant: got grant=%b busy=%b want 0000 0", grant_o, busy_o);
        end
        clear_all();
        @(posedge clk);
        #1;
        nreset_i = 1'b1;
        repeat (3) step();
        total++;
        if (busy_o !== 1'b0 || tx_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_after: got busy=%b txr=%b want 0 0", busy_o, tx_ready_o);
        end
    endtask

    task automatic test_single();
        int gerr;
        gerr = 0;
        do_reset();
        slen[1] = 2;
        sd[1][0] = 8'h11; sl[1][0] = 1'b0;
        sd[1][1] = 8'h22; sl[1][1] = 1'b1;
        auto_tx = 1'b1;
        drive_reqs();
        for (int c = 0; c < 100 && lg_n < 2; c++) begin
            step();
            if (busy_o && grant_o !== 4'b0010) gerr++;
        end
        total++;
        if (lg_n != 2) begin
            bad++;
            $display("FAIL single_count: got %0d want 2", lg_n);
        end
        total++;
        if (lg_data[0] !== 8'h11 || lg_data[1] !== 8'h22) begin
            bad++;
            $display("FAIL single_data: got %h %h want 11 22", lg_data[0], lg_data[1]);
        end
        total++;
        if (lg_grant[0] !== 4'b0010 || lg_grant[1] !== 4'b0010 || gerr != 0) begin
            bad++;
            $display("FAIL single_grant: got %b %b errs=%0d want 0010 0010 0",
                     lg_grant[0], lg_grant[1], gerr);
        end
        step();
        total++;
        if (busy_o !== 1'b0 || win_n != 2) begin
            bad++;
            $display("FAIL single_end: got busy=%b windows=%0d want 0 2", busy_o, win_n);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5];
        logic [3:0] exp_g [5];
        exp_d[0] = 8'hA0; exp_g[0] = 4'b0001;
        exp_d[1] = 8'hB0; exp_g[1] = 4'b0010;
        exp_d[2] = 8'hC0; exp_g[2] = 4'b0100;
        exp_d[3] = 8'hD0; exp_g[3] = 4'b1000;
        exp_d[4] = 8'hA1; exp_g[4] = 4'b0001;
        do_reset();
        slen[0] = 2; sd[0][0] = 8'hA0; sl[0][0] = 1'b1; sd[0][1] = 8'hA1; sl[0][1] = 1'b1;
        slen[1] = 1; sd[1][0] = 8'hB0; sl[1][0] = 1'b1;
        slen[2] = 1; sd[2][0] = 8'hC0; sl[2][0] = 1'b1;
        slen[3] = 1; sd[3][0] = 8'hD0; sl[3][0] = 1'b1;
        auto_tx = 1'b1;
        drive_reqs();
        run_bytes(5);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (lg_data[i] !== exp_d[i] || lg_grant[i] !== exp_g[i]) begin
                bad++;
                $display("FAIL rr_order[%0d]: got data=%h grant=%b want %h %b",
                         i, lg_data[i], lg_grant[i], exp_d[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_burst_limit();
        logic [7:0] exp_d [7];
        logic [3:0] exp_g [7];
        do_reset();
        slen[2] = 6;
        for (int i = 0; i < 6; i++) begin
            sd[2][i] = 8'h20 + 8'(i);
            sl[2][i] = (i == 5);
        end
        slen[3] = 1; sd[3][0] = 8'h30; sl[3][0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = 8'h20 + 8'(i);
            exp_g[i] = 4'b0100;
        end
        exp_d[4] = 8'h30; exp_g[4] = 4'b1000;
        exp_d[5] = 8'h24; exp_g[5] = 4'b0100;
        exp_d[6] = 8'h25; exp_g[6] = 4'b0100;
        auto_tx = 1'b1;
        drive_reqs();
        run_bytes(7);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (lg_data[i] !== exp_d[i] || lg_grant[i] !== exp_g[i]) begin
                bad++;
                $display("FAIL burst_order[%0d]: got data=%h grant=%b want %h %b",
                         i, lg_data[i], lg_grant[i], exp_d[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_idle_timeout();
        int txr_seen;
        txr_seen = 0;
        do_reset();
        auto_tx     = 1'b1;
        force_valid = 4'b0001;
        slen[1] = 1; sd[1][0] = 8'h5A; sl[1][0] = 1'b1;
        drive_reqs();
        step();
        total++;
        if (grant_o !== 4'b0001) begin
            bad++;
            $display("FAIL timeout_grant0: got %b want 0001", grant_o);
        end
        force_valid = 4'b0;
        drive_reqs();
        for (int i = 0; i < 15; i++) begin
            step();
            if (tx_ready_o) txr_seen++;
        end
        total++;
        if (grant_o !== 4'b0001) begin
            bad++;
            $display("FAIL timeout_held15: got %b want 0001", grant_o);
        end
        step();
        if (tx_ready_o) txr_seen++;
        total++;
        if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_release16: got grant=%b busy=%b want 0000 0", grant_o, busy_o);
        end
        step();
        total++;
        if (grant_o !== 4'b0010) begin
            bad++;
            $display("FAIL timeout_next_grant: got %b want 0010", grant_o);
        end
        total++;
        if (txr_seen != 0 || lg_n != 0) begin
            bad++;
            $display("FAIL timeout_spurious: got txr_cycles=%0d bytes=%0d want 0 0", txr_seen, lg_n);
        end
        run_bytes(1);
        total++;
        if (lg_data[0] !== 8'h5A || lg_grant[0] !== 4'b0010) begin
            bad++;
            $display("FAIL timeout_byte: got %h %b want 5a 0010", lg_data[0], lg_grant[0]);
        end
    endtask

    task automatic test_stray_tx_valid();
        do_reset();
        tx_valid_i = 1'b1;
        step();
        total++;
        if (busy_o !== 1'b0 || tx_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL stray_idle: got busy=%b txr=%b want 0 0", busy_o, tx_ready_o);
        end
        slen[1] = 2;
        sd[1][0] = 8'h61; sl[1][0] = 1'b0;
        sd[1][1] = 8'h62; sl[1][1] = 1'b1;
        drive_reqs();
        tx_valid_i = 1'b1;
        step();
        total++;
        if (req_ready_o !== 4'b0010) begin
            bad++;
            $display("FAIL stray_xfer_ready: got %b want 0010", req_ready_o);
        end
        tx_valid_i = 1'b1;
        step();
        total++;
        if (tx_ready_o !== 1'b1 || tx_data_o !== 8'h61) begin
            bad++;
            $display("FAIL stray_send: got txr=%b data=%h want 1 61", tx_ready_o, tx_data_o);
        end
        step();
        total++;
        if (tx_ready_o !== 1'b1 || tx_data_o !== 8'h61) begin
            bad++;
            $display("FAIL stray_hold: got txr=%b data=%h want 1 61", tx_ready_o, tx_data_o);
        end
        auto_tx = 1'b1;
        run_bytes(2);
        repeat (10) step();
        total++;
        if (lg_n != 2 || lg_data[0] !== 8'h61 || lg_data[1] !== 8'h62) begin
            bad++;
            $display("FAIL stray_bytes: got n=%0d %h %h want 2 61 62", lg_n, lg_data[0], lg_data[1]);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        nreset_i    = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        tx_valid_i  = 1'b0;
        force_valid = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_limit();
        test_idle_timeout();
        test_stray_tx_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
